// File: rtl/bcd_to_binary_seq_if.sv
// Handshake and data bundle for the sequential BCD-to-binary converter.
// Carries the request digits toward the converter and the result back to the requester.
// START/BUSY/DONE handshake; one conversion at a time, with no queueing.
`timescale 1ns/1ps
interface bcd_to_binary_seq_if;
    logic       START;
    logic [1:0] HUNDREDS;
    logic [3:0] TENS;
    logic [3:0] ONES;
    logic [7:0] BIN;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    modport master (
        output START, HUNDREDS, TENS, ONES,
        input  BIN, BUSY, DONE, ERR
    );

    modport slave (
        input  START, HUNDREDS, TENS, ONES,
        output BIN, BUSY, DONE, ERR
    );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble).
// Latency: DONE 11 cycles after an accepted START (2 cycles for an invalid digit).
// Backpressure: START is ignored unless the FSM is in IDLE; nothing is queued.
// Optional macro BCD_SAT_EN: an over-range result saturates to MAX_VAL instead of 0.
`timescale 1ns/1ps
module bcd_to_binary_seq #(
    parameter int MAX_VAL = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_to_binary_seq_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SHIFT, S_DONE} state_t;

    localparam logic [8:0] MAX9 = 9'(MAX_VAL);

    state_t      r_state;
    logic [9:0]  r_bcd;
    logic [8:0]  r_bin;
    logic [3:0]  r_cnt;
    logic [7:0]  r_bin_o;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic [18:0] w_shift;
    logic [9:0]  w_bcd_nxt;
    logic [8:0]  w_bin_nxt;
    logic        w_digit_bad;
    logic        w_over;
    logic [7:0]  w_over_val;

    // One reverse double-dabble step: shift right, then pull each decimal digit back by 3 when >= 8.
    // The hundreds field is only 2 bits wide, so it can never reach 8 and needs no correction.
    always_comb begin
        w_shift   = {r_bcd, r_bin} >> 1;
        w_bcd_nxt = w_shift[18:9];
        w_bin_nxt = w_shift[8:0];
        if (w_bcd_nxt[7:4] >= 4'd8) w_bcd_nxt[7:4] = w_bcd_nxt[7:4] - 4'd3;
        if (w_bcd_nxt[3:0] >= 4'd8) w_bcd_nxt[3:0] = w_bcd_nxt[3:0] - 4'd3;
        w_digit_bad = (r_bcd[7:4] > 4'd9) || (r_bcd[3:0] > 4'd9);
        w_over      = (w_bin_nxt > MAX9);
`ifdef BCD_SAT_EN
        w_over_val  = MAX9[7:0];
`else
        w_over_val  = 8'd0;
`endif
    end

    // Control FSM with registered outputs; BIN/ERR only change on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_cnt   <= '0;
            r_bin_o <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.START) begin
                        r_bcd   <= {bus.HUNDREDS, bus.TENS, bus.ONES};
                        r_bin   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_digit_bad) begin
                        r_bin_o <= 8'd0;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= w_bcd_nxt;
                    r_bin <= w_bin_nxt;
                    if (r_cnt == 4'd8) begin
                        // Ninth step: the result is complete in w_bin_nxt, publish it now.
                        r_cnt   <= '0;
                        r_bin_o <= w_over ? w_over_val : w_bin_nxt[7:0];
                        r_err   <= w_over;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    // START is deliberately ignored here.
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.BIN  = r_bin_o;
    assign bus.BUSY = r_busy;
    assign bus.DONE = r_done;
    assign bus.ERR  = r_err;
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed bench for bcd_to_binary_seq: latency, results, errors, handshake and reset abort.
// A second instance with MAX_VAL=99 shares the request inputs to exercise the over-range limit.
// Outputs are sampled on the falling edge; inputs change on the falling edge or just after the rising edge.
`timescale 1ns/1ps
module tb_bcd_to_binary_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bcd_to_binary_seq_if u_if ();
    bcd_to_binary_seq_if u_if99 ();

    assign u_if99.START    = u_if.START;
    assign u_if99.HUNDREDS = u_if.HUNDREDS;
    assign u_if99.TENS     = u_if.TENS;
    assign u_if99.ONES     = u_if.ONES;

    bcd_to_binary_seq #(.MAX_VAL(255)) u_dut   (.clk(clk), .rst_n(rst_n), .bus(u_if));
    bcd_to_binary_seq #(.MAX_VAL(99))  u_dut99 (.clk(clk), .rst_n(rst_n), .bus(u_if99));

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BCD_SAT_EN
    localparam logic [7:0] OVR255 = 8'hFF;
    localparam logic [7:0] OVR99  = 8'h63;
`else
    localparam logic [7:0] OVR255 = 8'h00;
    localparam logic [7:0] OVR99  = 8'h00;
`endif

    // Launch one conversion and follow it to DONE; optionally pulse START again at cycle inj_cyc.
    task automatic run(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                       input int inj_cyc,
                       output int done_cyc, output int busy_cnt, output logic [7:0] bin,
                       output logic err, output logic held, output logic done_after);
        logic [7:0] b0;
        logic       e0;
        @(negedge clk);
        u_if.HUNDREDS = h; u_if.TENS = t; u_if.ONES = o; u_if.START = 1'b1;
        b0 = u_if.BIN; e0 = u_if.ERR;
        @(posedge clk);
        #1;
        u_if.START = 1'b0;
        u_if.HUNDREDS = 2'd0; u_if.TENS = 4'd0; u_if.ONES = 4'd1;
        done_cyc = -1; busy_cnt = 0; held = 1'b1; bin = 8'h00; err = 1'b0;
        for (int c = 1; c <= 30 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == inj_cyc + 1) u_if.START = 1'b0;
            if (u_if.BUSY === 1'b1) busy_cnt++;
            if (u_if.DONE === 1'b1) begin
                done_cyc = c; bin = u_if.BIN; err = u_if.ERR;
            end else if (u_if.BIN !== b0 || u_if.ERR !== e0) begin
                held = 1'b0;
            end
            if (c == inj_cyc) u_if.START = 1'b1;
        end
        u_if.START = 1'b0;
        @(negedge clk);
        done_after = u_if.DONE;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        u_if.START = 1'b0; u_if.HUNDREDS = 2'd0; u_if.TENS = 4'd0; u_if.ONES = 4'd0;
        repeat (3) @(negedge clk);
        checks++; if (u_if.BIN !== 8'h00)  begin errors++; $display("FAIL reset_bin got %h want 00", u_if.BIN); end
        checks++; if (u_if.BUSY !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", u_if.BUSY); end
        checks++; if (u_if.DONE !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", u_if.DONE); end
        checks++; if (u_if.ERR !== 1'b0)   begin errors++; $display("FAIL reset_err got %b want 0", u_if.ERR); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int dc, bc; logic [7:0] b; logic e, hd, da;
        run(2'd1, 4'd2, 4'd7, -5, dc, bc, b, e, hd, da);
        checks++; if (dc !== 11)       begin errors++; $display("FAIL basic_latency got %0d want 11", dc); end
        checks++; if (bc !== 10)       begin errors++; $display("FAIL basic_busy_cycles got %0d want 10", bc); end
        checks++; if (b !== 8'h7F)     begin errors++; $display("FAIL basic_bin got %h want 7f", b); end
        checks++; if (e !== 1'b0)      begin errors++; $display("FAIL basic_err got %b want 0", e); end
        checks++; if (hd !== 1'b1)     begin errors++; $display("FAIL basic_held got %b want 1", hd); end
        checks++; if (da !== 1'b0)     begin errors++; $display("FAIL basic_done_pulse got %b want 0", da); end
    endtask

    task automatic test_mid_reset;
        int dc, bc, seen; logic [7:0] b; logic e, hd, da;
        @(negedge clk);
        u_if.HUNDREDS = 2'd2; u_if.TENS = 4'd5; u_if.ONES = 4'd5; u_if.START = 1'b1;
        @(posedge clk);
        #1 u_if.START = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (u_if.BUSY !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", u_if.BUSY); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (u_if.BIN !== 8'h00) begin errors++; $display("FAIL midrst_bin got %h want 00", u_if.BIN); end
        checks++; if (u_if.BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", u_if.BUSY); end
        checks++; if (u_if.DONE !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", u_if.DONE); end
        checks++; if (u_if.ERR !== 1'b0)  begin errors++; $display("FAIL midrst_err got %b want 0", u_if.ERR); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (u_if.DONE === 1'b1 || u_if.BUSY === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_aborted got %0d active cycles want 0", seen); end
        run(2'd0, 4'd5, 4'd9, -5, dc, bc, b, e, hd, da);
        checks++; if (dc !== 11)   begin errors++; $display("FAIL after_rst_latency got %0d want 11", dc); end
        checks++; if (b !== 8'h3B) begin errors++; $display("FAIL after_rst_bin got %h want 3b", b); end
        checks++; if (e !== 1'b0)  begin errors++; $display("FAIL after_rst_err got %b want 0", e); end
    endtask

    task automatic test_sweep;
        int dc, bc; logic [7:0] b; logic e, hd, da;
        for (int v = 0; v < 256; v++) begin
            run(2'(v / 100), 4'((v / 10) % 10), 4'(v % 10), -5, dc, bc, b, e, hd, da);
            checks++;
            if (b !== 8'(v) || e !== 1'b0 || dc !== 11) begin
                errors++;
                $display("FAIL sweep_%0d got bin=%0d err=%b cyc=%0d want bin=%0d err=0 cyc=11", v, b, e, dc, v);
            end
        end
    endtask

    task automatic test_invalid;
        int dc, bc; logic [7:0] b; logic e, hd, da;
        run(2'd1, 4'hA, 4'd3, -5, dc, bc, b, e, hd, da);
        checks++; if (dc !== 2)    begin errors++; $display("FAIL inv_tens_latency got %0d want 2", dc); end
        checks++; if (e !== 1'b1)  begin errors++; $display("FAIL inv_tens_err got %b want 1", e); end
        checks++; if (b !== 8'h00) begin errors++; $display("FAIL inv_tens_bin got %h want 00", b); end
        checks++; if (bc !== 1)    begin errors++; $display("FAIL inv_tens_busy got %0d want 1", bc); end
        run(2'd0, 4'd0, 4'hF, -5, dc, bc, b, e, hd, da);
        checks++; if (dc !== 2)    begin errors++; $display("FAIL inv_ones_latency got %0d want 2", dc); end
        checks++; if (e !== 1'b1)  begin errors++; $display("FAIL inv_ones_err got %b want 1", e); end
        checks++; if (b !== 8'h00) begin errors++; $display("FAIL inv_ones_bin got %h want 00", b); end
    endtask

    task automatic test_over_range;
        int dc, bc; logic [7:0] b; logic e, hd, da;
        run(2'd3, 4'd0, 4'd0, -5, dc, bc, b, e, hd, da);
        checks++; if (dc !== 11)    begin errors++; $display("FAIL ovr300_latency got %0d want 11", dc); end
        checks++; if (e !== 1'b1)   begin errors++; $display("FAIL ovr300_err got %b want 1", e); end
        checks++; if (b !== OVR255) begin errors++; $display("FAIL ovr300_bin got %h want %h", b, OVR255); end
        run(2'd1, 4'd0, 4'd0, -5, dc, bc, b, e, hd, da);
        checks++; if (b !== 8'd100 || e !== 1'b0) begin errors++; $display("FAIL max255_100 got bin=%0d err=%b want 100/0", b, e); end
        checks++; if (u_if99.ERR !== 1'b1)  begin errors++; $display("FAIL max99_100_err got %b want 1", u_if99.ERR); end
        checks++; if (u_if99.BIN !== OVR99) begin errors++; $display("FAIL max99_100_bin got %h want %h", u_if99.BIN, OVR99); end
        run(2'd0, 4'd9, 4'd9, -5, dc, bc, b, e, hd, da);
        checks++; if (u_if99.ERR !== 1'b0 || u_if99.BIN !== 8'd99) begin
            errors++; $display("FAIL max99_99 got bin=%0d err=%b want 99/0", u_if99.BIN, u_if99.ERR);
        end
    endtask

    task automatic test_ignore_start;
        int dc, bc; logic [7:0] b; logic e, hd, da;
        run(2'd2, 4'd5, 4'd5, 5, dc, bc, b, e, hd, da);
        checks++; if (dc !== 11)    begin errors++; $display("FAIL ignore_latency got %0d want 11", dc); end
        checks++; if (b !== 8'hFF)  begin errors++; $display("FAIL ignore_bin got %h want ff", b); end
        checks++; if (e !== 1'b0)   begin errors++; $display("FAIL ignore_err got %b want 0", e); end
        checks++; if (u_if.BUSY !== 1'b0) begin errors++; $display("FAIL ignore_no_queue got busy %b want 0", u_if.BUSY); end
    endtask

    task automatic test_back_to_back;
        int d1, d2; logic [7:0] b1, b2;
        d1 = -1; d2 = -1; b1 = 8'h00; b2 = 8'h00;
        @(negedge clk);
        u_if.HUNDREDS = 2'd0; u_if.TENS = 4'd4; u_if.ONES = 4'd2; u_if.START = 1'b1;
        @(posedge clk);
        #1;
        u_if.HUNDREDS = 2'd1; u_if.TENS = 4'd3; u_if.ONES = 4'd7;
        for (int c = 1; c <= 40 && d2 < 0; c++) begin
            @(negedge clk);
            if (u_if.DONE === 1'b1) begin
                if (d1 < 0) begin d1 = c; b1 = u_if.BIN; end
                else begin d2 = c; b2 = u_if.BIN; u_if.START = 1'b0; end
            end
        end
        u_if.START = 1'b0;
        checks++; if (d1 !== 11)    begin errors++; $display("FAIL b2b_first_cyc got %0d want 11", d1); end
        checks++; if (b1 !== 8'd42) begin errors++; $display("FAIL b2b_first_bin got %0d want 42", b1); end
        checks++; if (d2 !== 23)    begin errors++; $display("FAIL b2b_second_cyc got %0d want 23", d2); end
        checks++; if (b2 !== 8'd137) begin errors++; $display("FAIL b2b_second_bin got %0d want 137", b2); end
        repeat (3) @(negedge clk);
        checks++; if (u_if.BUSY !== 1'b0) begin errors++; $display("FAIL b2b_idle_after got busy %b want 0", u_if.BUSY); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_mid_reset();
        test_invalid();
        test_over_range();
        test_ignore_start();
        test_back_to_back();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
